// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the pipe_skid_reg stage register family:
// reset level, FSM state encodings and per-stage payload widths.
package pipe_skid_reg_pkg;

    localparam logic RstEnable = 1'b1;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'b00,
        PIPE_ONE   = 2'b01,
        PIPE_FULL  = 2'b10
    } pipe_state_e;

    // pc/inst for IF/ID; full decoded bundle for ID/EX; result bundle for EX/MEM
    localparam int IfIdPayloadW  = 64;
    localparam int IdExPayloadW  = 148;
    localparam int ExMemPayloadW = 112;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle of one pipe_skid_reg stage; slave is the register's view,
// master is the view of whatever drives it (neighbouring stages or a bench).
interface pipe_skid_reg_if #(
    parameter int DATA_W = 148
);
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;

    modport slave (
        input  flush_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o
    );

    modport master (
        output flush_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating up-counter with enable, used for the optional stage performance
// counters (present only when PIPE_SKID_PERF_EN is defined).
module pipe_perf_cnt
    import pipe_skid_reg_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            cnt_o <= '0;
        end else if (en && (cnt_o != {CNT_W{1'b1}})) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Parametrised inter-stage register with valid/ready handshake and 2-entry skid.
// Optional stall/bubble counters are built when PIPE_SKID_PERF_EN is defined.
//
//   state      | meaning
//   PIPE_EMPTY | no entry held, output is a bubble (NOP_VALUE)
//   PIPE_ONE   | main slot valid, skid slot empty
//   PIPE_FULL  | main and skid slots valid, upstream is stalled
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int                DATA_W    = IdExPayloadW,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_skid_reg_if.slave   bus
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
`endif
);

    if (DATA_W < 1 || CNT_W < 1) begin : g_param_chk
        $error("pipe_skid_reg: DATA_W and CNT_W must be positive");
    end

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              out_valid;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;

    // Handshake outputs depend on registered state only, keeping ready/valid
    // free of combinational paths through the stage.
    assign out_valid = (state_q != PIPE_EMPTY);
    assign in_ready  = (state_q != PIPE_FULL);
    assign in_fire   = bus.in_valid_i & in_ready;
    assign out_fire  = out_valid & bus.out_ready_i;

    assign bus.out_valid_o = out_valid;
    assign bus.in_ready_o  = in_ready;
    assign bus.out_data_o  = out_valid ? main_q : NOP_VALUE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q <= PIPE_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush_i) begin
            state_d = PIPE_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state_q)
                PIPE_EMPTY: begin
                    if (in_fire) begin
                        main_d  = bus.in_data_i;
                        state_d = PIPE_ONE;
                    end
                end
                PIPE_ONE: begin
                    case ({in_fire, out_fire})
                        2'b11: main_d = bus.in_data_i;
                        2'b10: begin
                            skid_d  = bus.in_data_i;
                            state_d = PIPE_FULL;
                        end
                        2'b01: begin
                            main_d  = NOP_VALUE;
                            state_d = PIPE_EMPTY;
                        end
                        default: ;
                    endcase
                end
                PIPE_FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                        state_d = PIPE_ONE;
                    end
                end
                default: begin
                    state_d = PIPE_EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_PERF_EN
    pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (out_valid & ~bus.out_ready_i),
        .cnt_o (stall_cnt_o)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (~out_valid),
        .cnt_o (bubble_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus random traffic
// compared against a 2-deep FIFO reference model (PIPE_SKID_PERF_EN optional).
module tb_pipe_skid_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_skid_reg_if #(.DATA_W(DATA_W)) bus ();

`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;
`endif

    pipe_skid_reg #(
        .DATA_W    (DATA_W),
        .NOP_VALUE ({DATA_W{1'b0}}),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PIPE_SKID_PERF_EN
        ,
        .stall_cnt_o  (stall_cnt),
        .bubble_cnt_o (bubble_cnt)
`endif
    );

    // Reference model: the stage is a FIFO of capacity two.
    logic [DATA_W-1:0] q[$];
    int stall_m;
    int bubble_m;
    int n_assert;
    int n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [DATA_W-1:0] exp_data;
        exp_data = (q.size() > 0) ? q[0] : '0;
        chk({tag, ".out_valid"}, 64'(bus.out_valid_o), 64'(q.size() > 0));
        chk({tag, ".in_ready"},  64'(bus.in_ready_o),  64'(q.size() < 2));
        chk({tag, ".out_data"},  64'(bus.out_data_o),  64'(exp_data));
`ifdef PIPE_SKID_PERF_EN
        chk({tag, ".stall_cnt"},  64'(stall_cnt),  64'(stall_m));
        chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(bubble_m));
`endif
    endtask

    task automatic model_reset();
        q.delete();
        stall_m  = 0;
        bubble_m = 0;
    endtask

    // One clock of stimulus; model advances from pre-edge occupancy.
    task automatic cycle(input string tag, input logic v, input logic [DATA_W-1:0] d,
                         input logic r, input logic f);
        bit in_fire;
        bit out_fire;
        bus.in_valid_i  = v;
        bus.in_data_i   = d;
        bus.out_ready_i = r;
        bus.flush_i     = f;
        in_fire  = v && (q.size() < 2);
        out_fire = (q.size() > 0) && r;
        if (q.size() > 0 && !r && stall_m < CNT_MAX) stall_m++;
        if (q.size() == 0 && bubble_m < CNT_MAX) bubble_m++;
        @(posedge clk);
        #1;
        if (f) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back(d);
        end
        check_model(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, ".out_valid"}, 64'(bus.out_valid_o), 64'd0);
        chk({tag, ".out_data"},  64'(bus.out_data_o),  64'd0);
        chk({tag, ".in_ready"},  64'(bus.in_ready_o),  64'd1);
`ifdef PIPE_SKID_PERF_EN
        chk({tag, ".stall_cnt"},  64'(stall_cnt),  64'd0);
        chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        model_reset();
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;

        async_reset("reset");
        check_model("idle");

        // Streaming at one item per cycle
        cycle("stream0", 1'b1, 32'h11, 1'b1, 1'b0);
        chk("stream0.const", 64'(bus.out_data_o), 64'h11);
        cycle("stream1", 1'b1, 32'h22, 1'b1, 1'b0);
        chk("stream1.const", 64'(bus.out_data_o), 64'h22);
        cycle("stream2", 1'b1, 32'h33, 1'b1, 1'b0);
        chk("stream2.const", 64'(bus.out_data_o), 64'h33);
        chk("stream2.ready", 64'(bus.in_ready_o), 64'd1);
        cycle("stream_end", 1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure fills the skid slot; held input must be ignored
        cycle("bp0", 1'b1, 32'hA0, 1'b0, 1'b0);
        cycle("bp1", 1'b1, 32'hA1, 1'b0, 1'b0);
        chk("bp1.full", 64'(bus.in_ready_o), 64'd0);
        cycle("bp2", 1'b1, 32'hA2, 1'b0, 1'b0);
        cycle("bp3", 1'b1, 32'hFF, 1'b0, 1'b0);
        chk("bp3.const", 64'(bus.out_data_o), 64'hA0);
        cycle("bp4", 1'b1, 32'hA2, 1'b1, 1'b0);
        chk("bp4.const", 64'(bus.out_data_o), 64'hA1);
        cycle("bp5", 1'b1, 32'hA2, 1'b1, 1'b0);
        chk("bp5.const", 64'(bus.out_data_o), 64'hA2);
        cycle("bp6", 1'b0, 32'h0, 1'b1, 1'b0);

        // Drain of a single item back to a bubble
        cycle("drain0", 1'b1, 32'h5, 1'b1, 1'b0);
        cycle("drain1", 1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain1.valid", 64'(bus.out_valid_o), 64'd0);
        chk("drain1.data",  64'(bus.out_data_o),  64'd0);
        cycle("empty_rdy", 1'b0, 32'h0, 1'b1, 1'b0);

        // Flush from FULL with a pending input
        cycle("fl0", 1'b1, 32'hB0, 1'b0, 1'b0);
        cycle("fl1", 1'b1, 32'hB1, 1'b0, 1'b0);
        cycle("fl2", 1'b1, 32'hB2, 1'b0, 1'b1);
        chk("fl2.valid", 64'(bus.out_valid_o), 64'd0);
        chk("fl2.ready", 64'(bus.in_ready_o),  64'd1);
        cycle("fl3", 1'b0, 32'h0, 1'b1, 1'b0);

        // Flush in ONE with simultaneous in_fire and out_fire
        cycle("fl4", 1'b1, 32'hC0, 1'b0, 1'b0);
        cycle("fl5", 1'b1, 32'hC1, 1'b1, 1'b1);

        // Reset in the middle of a transfer
        cycle("mid0", 1'b1, 32'hD0, 1'b0, 1'b0);
        cycle("mid1", 1'b1, 32'hD1, 1'b0, 1'b0);
        async_reset("midrst");
        cycle("mid2", 1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic against the FIFO model
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end

`ifdef PIPE_SKID_PERF_EN
        async_reset("perf_rst");
        cycle("perf_load", 1'b1, 32'hE0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle("perf_stall", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("perf.stall_sat", 64'(stall_cnt), 64'hF);
        cycle("perf_flush", 1'b0, 32'h0, 1'b0, 1'b1);
        chk("perf.flush_keep", 64'(stall_cnt), 64'hF);
        async_reset("perf_clr");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM style).
- Generic payload width, with a valid/ready handshake in place of the global stall bus.
- A 2-entry skid buffer gives full throughput and a registered ready path.
- Synchronous flush. Bubble semantics: the payload reads NOP_VALUE whenever the output is invalid.

Parameters:
DATA_W, 148, payload width in bits (concatenated pc/aluop/alusel/reg1/reg2/imm/wd/wreg for an ID/EX instance)
NOP_VALUE, {DATA_W{1'b0}}, payload driven and loaded on reset, flush and drain (encodes the NOP bundle)
CNT_W, 32, width of performance counters (only used when PIPE_SKID_PERF_EN is defined)

Ports:
clk  input  1  stage clock, rising edge
rst  input  1  asynchronous, active-high reset
flush_i  input  1  synchronous flush; kills both entries (branch/exception redirect)
in_valid_i  input  1  upstream payload valid
in_ready_o  output  1  buffer can accept; derived only from registered state
in_data_i  input  DATA_W  upstream payload
out_valid_o  output  1  downstream payload valid
out_ready_i  input  1  downstream accepts this cycle
out_data_o  output  DATA_W  downstream payload; equals NOP_VALUE when out_valid_o=0

Behaviour:
- Definitions:
  - in_fire = in_valid_i & in_ready_o
  - out_fire = out_valid_o & out_ready_i
- Storage: main slot (drives out_data_o) and skid slot.
- State machine: EMPTY (0 entries), ONE (main valid), FULL (main+skid valid).
- Combinational outputs from state only:
  - out_valid_o = (state != EMPTY)
  - in_ready_o = (state != FULL)
  - No combinational path from in_valid_i/out_ready_i to either output.
- Reset (async, rst=1): state=EMPTY, main=skid=NOP_VALUE. Resulting outputs: out_valid_o=0, out_data_o=NOP_VALUE, in_ready_o=1.
- Flush (sync, highest priority after reset): next state=EMPTY, main=skid=NOP_VALUE.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as consumed by downstream; the flush unit owns any kill.
- EMPTY transitions:
  - in_fire -> main<=in_data_i, state ONE.
  - otherwise hold.
- ONE transitions:
  - in_fire & out_fire -> main<=in_data_i, stay ONE. This is the 1-per-cycle throughput path.
  - in_fire & !out_fire -> skid<=in_data_i, state FULL.
  - !in_fire & out_fire -> main<=NOP_VALUE, state EMPTY.
  - neither -> hold.
- FULL transitions (in_fire impossible):
  - out_fire -> main<=skid, skid<=NOP_VALUE, state ONE.
  - else hold.
- Latency:
  - 1 cycle from in_fire to out_valid_o when empty.
  - Ordering is strictly FIFO; no payload is duplicated or dropped except on flush.
- Boundaries:
  - in_valid_i held with changing data while in_ready_o=0: ignored.
  - out_ready_i=1 while EMPTY: no effect.
  - Reset asserted mid-transfer: all entries lost, outputs at reset values immediately.
- Illegal encodings: unreachable state encodings recover to EMPTY on the next clock.

Optional Feature:
- Macro PIPE_SKID_PERF_EN.
- Defined: adds two output ports.
  - stall_cnt_o[CNT_W-1:0]: increments each cycle out_valid_o & !out_ready_i.
  - bubble_cnt_o[CNT_W-1:0]: increments each cycle !out_valid_o.
  - Both counters saturate at all-ones, clear on rst, and are not cleared by flush_i.
- Undefined: ports and counters absent; block behaviour identical otherwise.

Decomposition:
- Shared defines file holds:
  - RstEnable.
  - State encodings PIPE_EMPTY=2'b00, PIPE_ONE=2'b01, PIPE_FULL=2'b10.
  - Per-stage payload width constants, e.g. IdExPayloadW.
- One sub-module, pipe_perf_cnt:
  - Saturating CNT_W counter with enable.
  - Instantiated twice, only under PIPE_SKID_PERF_EN.

Test Plan (DATA_W=32, NOP_VALUE=0):
- Reset/idle: rst pulse mid-cycle -> out_valid_o=0, out_data_o=0, in_ready_o=1 asynchronously.
- Streaming: out_ready_i=1, send 0x11,0x22,0x33 back-to-back -> out_data_o shows 0x11,0x22,0x33 on consecutive cycles, one cycle after each input; in_ready_o stays 1.
- Backpressure: out_ready_i=0, send 0xA0,0xA1 -> state FULL, in_ready_o=0; 0xA2 held on input is not taken. Raise out_ready_i -> outputs 0xA0, 0xA1, 0xA2 in order, none lost.
- Drain: single 0x5 with out_ready_i=1 and no further input -> after consumption out_valid_o=0 and out_data_o=0.
- Flush: FULL with 0xB0/0xB1 and in_valid_i=1 with 0xB2, assert flush_i one cycle -> next cycle out_valid_o=0, out_data_o=0, in_ready_o=1; 0xB0–0xB2 never appear.
- Perf (PIPE_SKID_PERF_EN, CNT_W=4):
  - 20 cycles out_valid_o=1 with out_ready_i=0 -> stall_cnt_o saturates at 0xF.
  - flush_i does not clear it; rst does.
